// File: rtl/complex_divide.sv
// Iterative fixed-point complex divider z = x / y, signed Q1.(H-1) halves.
// Define COMPLEX_DIVIDE_ROUND_EN for round-to-nearest instead of truncation.
module complex_divide #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf,
  output logic             div0
);

  localparam int H = WIDTH / 2;
  localparam int F = H - 1;
  localparam int P = 2 * H;
  localparam int N = 2 * H + 1;
  localparam int R = N + 1;
`ifdef COMPLEX_DIVIDE_ROUND_EN
  localparam int NIT = F + 1;
`else
  localparam int NIT = F;
`endif
  localparam int CW = $clog2(NIT) + 1;

  typedef enum logic [2:0] {
    IDLE, MUL, PREP, DIV, OUT
  } state_t;

  state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic ovf_q, ovf_d, div0_q, div0_d;

  logic signed [H-1:0] xre_q, xre_d, xim_q, xim_d;
  logic signed [H-1:0] yre_q, yre_d, yim_q, yim_d;
  logic signed [P-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [P-1:0] p_ir_q, p_ir_d, p_ri_q, p_ri_d;
  logic signed [P-1:0] p_yr_q, p_yr_d, p_yi_q, p_yi_d;
  logic [N-1:0] den_q, den_d;
  logic [R-1:0] rem_re_q, rem_re_d, rem_im_q, rem_im_d;
  logic [NIT-1:0] q_re_q, q_re_d, q_im_q, q_im_d;
  logic sgn_re_q, sgn_re_d, sgn_im_q, sgn_im_d;
  logic sat_re_q, sat_re_d, sat_im_q, sat_im_d;
  logic zd_q, zd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [N-1:0] num_re, num_im;
  logic [N-1:0] den_c, mag_re, mag_im;
  logic [R:0] r2_re, r2_im, dext;
  logic b_re, b_im;
  logic [R-1:0] rn_re, rn_im;
  logic [H:0] f_re, f_im;

  function automatic logic [H:0] fin(
    input logic [NIT-1:0] q,
    input logic           s,
    input logic           sat,
    input logic           zd
  );
    logic [H-1:0] m;
    logic         o;
`ifdef COMPLEX_DIVIDE_ROUND_EN
    // Guard bit rounds half up; a carry into bit F means 2^F, which saturates.
    m = H'(q[NIT-1:1]) + H'(q[0]);
    o = sat | m[H-1];
`else
    m = H'(q);
    o = sat;
`endif
    if (zd) begin
      m = '0;
      o = 1'b0;
    end else if (o) begin
      m = {1'b0, {F{1'b1}}};
    end
    if (s) m = -m;
    return {o, m};
  endfunction

  always_comb begin
    num_re = N'(p_rr_q) + N'(p_ii_q);
    num_im = N'(p_ir_q) - N'(p_ri_q);
    den_c  = $unsigned(N'(p_yr_q) + N'(p_yi_q));
    mag_re = num_re[N-1] ? $unsigned(-num_re) : $unsigned(num_re);
    mag_im = num_im[N-1] ? $unsigned(-num_im) : $unsigned(num_im);

    dext  = (R + 1)'(den_q);
    r2_re = {rem_re_q, 1'b0};
    r2_im = {rem_im_q, 1'b0};
    b_re  = r2_re >= dext;
    b_im  = r2_im >= dext;
    rn_re = b_re ? R'(r2_re - dext) : R'(r2_re);
    rn_im = b_im ? R'(r2_im - dext) : R'(r2_im);

    f_re = fin(q_re_q, sgn_re_q, sat_re_q, zd_q);
    f_im = fin(q_im_q, sgn_im_q, sat_im_q, zd_q);
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    xre_d = xre_q;
    xim_d = xim_q;
    yre_d = yre_q;
    yim_d = yim_q;
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ir_d = p_ir_q;
    p_ri_d = p_ri_q;
    p_yr_d = p_yr_q;
    p_yi_d = p_yi_q;
    den_d    = den_q;
    rem_re_d = rem_re_q;
    rem_im_d = rem_im_q;
    q_re_d   = q_re_q;
    q_im_d   = q_im_q;
    sgn_re_d = sgn_re_q;
    sgn_im_d = sgn_im_q;
    sat_re_d = sat_re_q;
    sat_im_d = sat_im_q;
    zd_d     = zd_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          xre_d = x[WIDTH-1:H];
          xim_d = x[H-1:0];
          yre_d = y[WIDTH-1:H];
          yim_d = y[H-1:0];
          in_ready_d = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        p_rr_d = P'(xre_q) * P'(yre_q);
        p_ii_d = P'(xim_q) * P'(yim_q);
        p_ir_d = P'(xim_q) * P'(yre_q);
        p_ri_d = P'(xre_q) * P'(yim_q);
        p_yr_d = P'(yre_q) * P'(yre_q);
        p_yi_d = P'(yim_q) * P'(yim_q);
        state_d = PREP;
      end
      PREP: begin
        den_d    = den_c;
        zd_d     = den_c == '0;
        sgn_re_d = num_re[N-1];
        sgn_im_d = num_im[N-1];
        sat_re_d = mag_re >= den_c;
        sat_im_d = mag_im >= den_c;
        rem_re_d = R'(mag_re);
        rem_im_d = R'(mag_im);
        q_re_d   = '0;
        q_im_d   = '0;
        cnt_d    = CW'(NIT);
        state_d  = DIV;
      end
      DIV: begin
        if (cnt_q == '0) begin
          z_d         = {f_re[H-1:0], f_im[H-1:0]};
          ovf_d       = f_re[H] | f_im[H];
          div0_d      = zd_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          rem_re_d = rn_re;
          rem_im_d = rn_im;
          q_re_d   = {q_re_q[NIT-2:0], b_re};
          q_im_d   = {q_im_q[NIT-2:0], b_im};
          cnt_d    = cnt_q - CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      xre_q <= '0;
      xim_q <= '0;
      yre_q <= '0;
      yim_q <= '0;
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
      p_yr_q <= '0;
      p_yi_q <= '0;
      den_q    <= '0;
      rem_re_q <= '0;
      rem_im_q <= '0;
      q_re_q   <= '0;
      q_im_q   <= '0;
      sgn_re_q <= 1'b0;
      sgn_im_q <= 1'b0;
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
      zd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      xre_q <= xre_d;
      xim_q <= xim_d;
      yre_q <= yre_d;
      yim_q <= yim_d;
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ir_q <= p_ir_d;
      p_ri_q <= p_ri_d;
      p_yr_q <= p_yr_d;
      p_yi_q <= p_yi_d;
      den_q    <= den_d;
      rem_re_q <= rem_re_d;
      rem_im_q <= rem_im_d;
      q_re_q   <= q_re_d;
      q_im_q   <= q_im_d;
      sgn_re_q <= sgn_re_d;
      sgn_im_q <= sgn_im_d;
      sat_re_q <= sat_re_d;
      sat_im_q <= sat_im_d;
      zd_q     <= zd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

endmodule
